multdiv: RTL and testbench
==========================

# multdiv

Multicycle signed 32-bit multiply/divide unit that sits beside the ALU in the execute stage. It takes the same operand pair the ALU receives, runs a radix-4 Booth multiply (16 steps) or a non-restoring divide (32 steps), and returns a one-cycle ready pulse. Its result and exception flag feed the execute-stage result mux and the X/M latch, alongside the ALU's `data_result` and `overflow`. Pipeline control stalls the front end from the start pulse until `data_resultRDY`.

## Interface
No parameters; widths are fixed at 32.

- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ctrl_MULT` in 1: one-cycle start pulse for a multiply.
- `ctrl_DIV` in 1: one-cycle start pulse for a divide.
- `data_operandA` in 32: multiplicand / dividend, two's complement; sampled only on the start edge.
- `data_operandB` in 32: multiplier / divisor, two's complement; sampled only on the start edge.
- `data_result` out 32: low 32 bits of the product, or the quotient.
- `data_exception` out 1: result is not representable, or divide by zero.
- `data_resultRDY` out 1: one-cycle pulse; `data_result` and `data_exception` are valid in that cycle.

## Operation
- States:
  - IDLE: waiting for a start pulse.
  - MUL: Booth steps; 5-bit counter `step`.
  - DIV: divide steps, then fixup.
  - DONE: outputs final, `data_resultRDY` asserted.
- Start:
  - On any edge with `ctrl_MULT`=1, in any state: latch operands, clear the accumulator, set `step`=0, go to MUL.
  - Else on any edge with `ctrl_DIV`=1: latch operands, clear the accumulator, set `step`=0, go to DIV.
  - A start pulse mid-operation aborts the current operation and restarts it; no RDY is produced for the aborted one.
  - MULT and DIV high together: MULT wins.
- MUL:
  - Each edge: recode 3 multiplier bits to {0, ±M, ±2M}, add via 34-bit adder, arithmetic-shift the {acc, Q} pair right by 2.
  - After step 15 (16th step), go to DONE.
  - Product P is 64 bits. `data_result` = P[31:0].
  - `data_exception` = 1 when P[63:31] is not all-zero or all-one.
- DIV:
  - Operate on magnitudes |A| and |B|, 33-bit.
  - Each edge: one non-restoring shift/add-or-subtract step.
  - Steps 0–31, then one fixup edge: restore the remainder sign and negate the quotient when sign(A) differs from sign(B). Then go to DONE.
  - Quotient truncates toward zero. The remainder is discarded.
  - B=0: result 0, exception=1. Still takes full latency.
  - A=0x80000000 with B=0xFFFFFFFF: result 0x80000000, exception=1.
- DONE:
  - `data_resultRDY`=1 for exactly one cycle, then IDLE.
  - `data_result` and `data_exception` hold their final values in IDLE until the next start edge or reset.
- Reset:
  - Any state goes to IDLE.
  - `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `step`=0, accumulator=0.
  - Reset overrides start pulses on the same edge.

## Timing
- Let the start pulse be sampled at edge N.
- MULT: steps run on edges N+1..N+16. `data_resultRDY` goes high after edge N+16 and low after N+17. Latency is 16 cycles.
- DIV: steps run on edges N+1..N+32, fixup on N+33. `data_resultRDY` goes high after edge N+33 and low after N+34. Latency is 33 cycles.
- A new start may be sampled in the DONE cycle itself; RDY still drops on the next edge.
- Operands may change freely after edge N.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `multdiv_pkg` contains:
  - state encoding (IDLE, MUL, DIV, DONE);
  - `MUL_STEPS`=16 and `DIV_STEPS`=32;
  - Booth recode constants.
- One sub-module, `addsub_34`: a 34-bit add/subtract with a `sub` control. It is shared by both datapaths; only one operation runs at a time.
- The FSM, counter and shift registers live in `multdiv`.

## Test plan
- Reset while busy: `reset` held for 2 edges mid-MUL → all outputs 0, state IDLE, no RDY pulse afterwards.
- Multiply, signed: MULT with A=7, B=-3 → RDY exactly 16 edges later, result 0xFFFFFFEB (-21), exception 0. Then A=0x00010000, B=0x00010000 → result 0, exception 1.
- Divide, truncation toward zero: DIV with A=-7, B=2 → RDY exactly 33 edges later, result 0xFFFFFFFD (-3), exception 0. Also A=100, B=-7 → result -14.
- Divide edge cases: B=0 → result 0, exception 1, RDY at 33 edges. A=0x80000000, B=-1 → result 0x80000000, exception 1.
- Restart and priority:
  - MULT 7×6 started, then DIV 20/4 pulsed at step 5 → single RDY, 33 edges after the DIV pulse, result 5.
  - MULT and DIV pulsed together with 3 and 4 → RDY at 16 edges, result 12.
- Hold and back-to-back:
  - After RDY, outputs stay stable for 10 idle cycles with RDY=0.
  - A start pulse in the DONE cycle yields a second RDY exactly 16 or 33 edges after that pulse.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide unit: FSM states, step counts,
// and the radix-4 Booth recoding used by the multiply datapath.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int MUL_STEPS = 16;
  localparam int DIV_STEPS = 32;

  // Booth digit as {zero, two, neg}: selects 0, M or 2M, optionally negated.
  typedef struct packed {
    logic zero;
    logic two;
    logic neg;
  } booth_t;

  localparam booth_t BOOTH_ZERO = 3'b100;
  localparam booth_t BOOTH_POS1 = 3'b000;
  localparam booth_t BOOTH_POS2 = 3'b010;
  localparam booth_t BOOTH_NEG1 = 3'b001;
  localparam booth_t BOOTH_NEG2 = 3'b011;

  function automatic booth_t booth_recode(input logic [2:0] bits);
    booth_t r;
    case (bits)
      3'b000, 3'b111: r = BOOTH_ZERO;
      3'b001, 3'b010: r = BOOTH_POS1;
      3'b011:         r = BOOTH_POS2;
      3'b100:         r = BOOTH_NEG2;
      3'b101, 3'b110: r = BOOTH_NEG1;
      default:        r = BOOTH_ZERO;
    endcase
    return r;
  endfunction

  // Unsigned magnitude; 0x80000000 maps to itself, which is correct unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] x);
    logic [31:0] r;
    if (x[31]) begin
      r = ~x + 32'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/multdiv_addsub_34.sv
// 34-bit adder/subtractor shared by the Booth multiply and the
// non-restoring divide datapaths.
module addsub_34 (
  input  logic [33:0] a_i,
  input  logic [33:0] b_i,
  input  logic        sub_i,
  output logic [33:0] sum_o
);

  assign sum_o = a_i + (b_i ^ {34{sub_i}}) + {33'd0, sub_i};

endmodule

// File: rtl/multdiv.sv
// Multicycle signed 32-bit multiply (radix-4 Booth, 16 steps) and divide
// (non-restoring on magnitudes, 32 steps plus fixup) with a one-cycle ready pulse.
module multdiv
  import multdiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  state_e      state_q;
  logic [4:0]  step_q;
  logic [33:0] acc_q;
  logic [31:0] q_q;
  logic        qm1_q;
  logic [32:0] m_q;
  logic        neg_q;
  logic        dbz_q;
  logic        fix_q;
  logic [31:0] result_q;
  logic        exc_q;
  logic        rdy_q;

  logic [33:0] acc_d;
  logic [31:0] q_d;
  logic        qm1_d;

  logic [33:0] add_a_s;
  logic [33:0] add_b_s;
  logic        add_sub_s;
  logic [33:0] sum_s;

  booth_t      bth_s;
  logic [63:0] product_s;
  logic        mul_exc_s;
  logic [31:0] quot_s;
  logic [31:0] div_res_s;
  logic        div_exc_s;

  assign bth_s = booth_recode({q_q[1:0], qm1_q});

  addsub_34 u_addsub (
    .a_i   (add_a_s),
    .b_i   (add_b_s),
    .sub_i (add_sub_s),
    .sum_o (sum_s)
  );

  // In DIV, m_q holds |B| zero-extended; in MUL it holds A sign-extended.
  always_comb begin
    add_a_s   = acc_q;
    add_b_s   = 34'd0;
    add_sub_s = 1'b0;
    case (state_q)
      ST_MUL: begin
        if (bth_s.zero) begin
          add_b_s = 34'd0;
        end else if (bth_s.two) begin
          add_b_s = {m_q, 1'b0};
        end else begin
          add_b_s = {m_q[32], m_q};
        end
        add_sub_s = bth_s.neg;
      end
      ST_DIV: begin
        add_b_s = {1'b0, m_q};
        if (fix_q) begin
          add_a_s   = acc_q;
          add_sub_s = 1'b0;
        end else begin
          add_a_s   = {acc_q[32:0], q_q[31]};
          add_sub_s = ~acc_q[33];
        end
      end
      default: begin
        add_a_s = acc_q;
      end
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    q_d   = q_q;
    qm1_d = qm1_q;
    case (state_q)
      ST_MUL: begin
        acc_d = {{2{sum_s[33]}}, sum_s[33:2]};
        q_d   = {sum_s[1:0], q_q[31:2]};
        qm1_d = q_q[1];
      end
      ST_DIV: begin
        if (fix_q) begin
          acc_d = acc_q[33] ? sum_s : acc_q;
        end else begin
          acc_d = sum_s;
          q_d   = {q_q[30:0], ~sum_s[33]};
        end
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  assign product_s = {acc_d[31:0], q_d};
  assign mul_exc_s = ~((&product_s[63:31]) | ~(|product_s[63:31]));

  // A positive quotient magnitude with bit 31 set only arises from 0x80000000 / -1.
  always_comb begin
    quot_s = neg_q ? (~q_q + 32'd1) : q_q;
    if (dbz_q) begin
      div_res_s = 32'd0;
      div_exc_s = 1'b1;
    end else begin
      div_res_s = quot_s;
      div_exc_s = q_q[31] & ~neg_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      step_q   <= 5'd0;
      acc_q    <= 34'd0;
      q_q      <= 32'd0;
      qm1_q    <= 1'b0;
      m_q      <= 33'd0;
      neg_q    <= 1'b0;
      dbz_q    <= 1'b0;
      fix_q    <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else if (ctrl_MULT) begin
      state_q <= ST_MUL;
      step_q  <= 5'd0;
      acc_q   <= 34'd0;
      q_q     <= data_operandB;
      qm1_q   <= 1'b0;
      m_q     <= {data_operandA[31], data_operandA};
      neg_q   <= 1'b0;
      dbz_q   <= 1'b0;
      fix_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else if (ctrl_DIV) begin
      state_q <= ST_DIV;
      step_q  <= 5'd0;
      acc_q   <= 34'd0;
      q_q     <= mag32(data_operandA);
      qm1_q   <= 1'b0;
      m_q     <= {1'b0, mag32(data_operandB)};
      neg_q   <= data_operandA[31] ^ data_operandB[31];
      dbz_q   <= (data_operandB == 32'd0);
      fix_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_MUL: begin
          acc_q  <= acc_d;
          q_q    <= q_d;
          qm1_q  <= qm1_d;
          step_q <= step_q + 5'd1;
          if (step_q == 5'(MUL_STEPS - 1)) begin
            state_q  <= ST_DONE;
            result_q <= product_s[31:0];
            exc_q    <= mul_exc_s;
            rdy_q    <= 1'b1;
          end
        end
        ST_DIV: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          if (fix_q) begin
            state_q  <= ST_DONE;
            fix_q    <= 1'b0;
            result_q <= div_res_s;
            exc_q    <= div_exc_s;
            rdy_q    <= 1'b1;
          end else begin
            step_q <= step_q + 5'd1;
            if (step_q == 5'(DIV_STEPS - 1)) begin
              fix_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv.sv
// Scoreboard bench for multdiv: expectations are queued at each start pulse
// and checked (value, exception, arrival edge) when data_resultRDY pulses.
module tb_multdiv;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t sb_q[$];

  multdiv dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                                 input int due);
    exp_t   e;
    longint p;
    int     qt;
    e.due = due;
    if (is_mul) begin
      p     = longint'(signed'(a)) * longint'(signed'(b));
      e.res = p[31:0];
      e.exc = !((p[63:31] == {33{1'b0}}) || (p[63:31] == {33{1'b1}}));
    end else if (b == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      qt    = signed'(a) / signed'(b);
      e.res = qt;
      e.exc = 1'b0;
    end
    return e;
  endfunction

  // Caller is at a negedge; returns at the next negedge after the start edge.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    sb_q.delete();
    if (m) sb_q.push_back(model(1'b1, a, b, cyc + 16));
    else if (d) sb_q.push_back(model(1'b0, a, b, cyc + 33));
    @(negedge clock);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clock);
    end
    if (sb_q.size() != 0) begin
      check_eq("rdy_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (data_resultRDY === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_rdy", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("result", {32'd0, data_result}, {32'd0, e.res});
        check_eq("exception", {63'd0, data_exception}, {63'd0, e.exc});
        check_eq("rdy_edge", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check_eq("rst_result", {32'd0, data_result}, 64'd0);
    check_eq("rst_exc", {63'd0, data_exception}, 64'd0);
    check_eq("rst_rdy", {63'd0, data_resultRDY}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // reset held for two edges in the middle of a multiply
    start_op(1'b1, 1'b0, 32'd7, 32'd9);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    sb_q.delete();
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check_eq("busy_rst_result", {32'd0, data_result}, 64'd0);
    check_eq("busy_rst_exc", {63'd0, data_exception}, 64'd0);
    check_eq("busy_rst_rdy", {63'd0, data_resultRDY}, 64'd0);
    reset = 1'b0;
    repeat (25) @(negedge clock);

    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_drain(40);
    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_drain(40);
    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_drain(50);
    start_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_drain(50);
    start_op(1'b0, 1'b1, 32'd12345, 32'd0);
    wait_drain(50);
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_drain(50);

    // restart: divide pulsed while a multiply is at step 5
    start_op(1'b1, 1'b0, 32'd7, 32'd6);
    repeat (5) @(negedge clock);
    start_op(1'b0, 1'b1, 32'd20, 32'd4);
    wait_drain(50);

    start_op(1'b1, 1'b1, 32'd3, 32'd4);
    wait_drain(40);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq("hold_rdy", {63'd0, data_resultRDY}, 64'd0);
      check_eq("hold_result", {32'd0, data_result}, 64'd12);
      check_eq("hold_exc", {63'd0, data_exception}, 64'd0);
    end

    // back-to-back: next start sampled on the edge that ends the DONE cycle
    start_op(1'b1, 1'b0, 32'd5, 32'd5);
    for (int i = 0; i < 40 && data_resultRDY !== 1'b1; i++) @(negedge clock);
    check_eq("b2b_first_rdy", {63'd0, data_resultRDY}, 64'd1);
    start_op(1'b0, 1'b1, 32'd9, 32'hFFFF_FFFD);
    wait_drain(50);
    for (int i = 0; i < 40 && data_resultRDY !== 1'b1; i++) @(negedge clock);
    start_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'h4000_0000);
    wait_drain(40);

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 2 == 1) b = 32'($urandom_range(0, 20)) - 32'd10;
      start_op(i < 4, i >= 4, a, b);
      wait_drain(50);
    end

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
